pipelined_carry_select_adder: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/BLOCK carry-select slices, one register stage per slice.
- Sustains one operation per clock behind a valid/ready handshake.
- Sits in the arithmetic datapath wherever wide add/sub must close timing at full clock rate.

---
 rtl/pipelined_carry_select_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_select_adder.sv
// rtl/pipelined_carry_select_adder.sv - pipelined carry-select add/sub, one BLOCK-bit slice per stage
// Each stage resolves one slice from the carry registered by the stage below it.
module pipelined_carry_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int NSTG = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_param_check
    $error("WIDTH must be a multiple of BLOCK");
  end

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? 1'b1 : c_in;

  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y,
                                            input logic ci);
    logic             cy;
    logic [BLOCK-1:0] sum;
    cy  = ci;
    sum = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i] = x[i] ^ y[i] ^ cy;
      cy     = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    return {cy, sum};
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int OPW = WIDTH - k * BLOCK;  // operand bits not yet consumed at this stage
    localparam int SW  = (k + 1) * BLOCK;    // sum bits resolved once this stage has fired

    logic [OPW-1:0] opa;
    logic [OPW-1:0] opb;
    logic           ci;
    logic           vld_in;
    logic [BLOCK:0] res0;
    logic [BLOCK:0] res1;
    logic [BLOCK:0] res;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    logic           cy_q;
    logic           vld_q;

    if (k == 0) begin : g_src
      assign opa    = a;
      assign opb    = b_eff;
      assign ci     = cin_eff;
      assign vld_in = accept;
      assign sum_d  = res[BLOCK-1:0];
    end else begin : g_src
      assign opa    = g_stg[k-1].g_hi.opa_q;
      assign opb    = g_stg[k-1].g_hi.opb_q;
      assign ci     = g_stg[k-1].cy_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sum_d  = {res[BLOCK-1:0], g_stg[k-1].sum_q};
    end

    assign res0 = ripple(opa[BLOCK-1:0], opb[BLOCK-1:0], 1'b0);
    assign res1 = ripple(opa[BLOCK-1:0], opb[BLOCK-1:0], 1'b1);
    assign res  = ci ? res1 : res0;

    // Data only loads with a valid beat, so a bubble never disturbs what s shows.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        if (vld_in) begin
          cy_q  <= res[BLOCK];
          sum_q <= sum_d;
        end
      end
    end

    if (k < NSTG - 1) begin : g_hi
      logic [OPW-BLOCK-1:0] opa_q;
      logic [OPW-BLOCK-1:0] opb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv && vld_in) begin
          opa_q <= opa[OPW-1:BLOCK];
          opb_q <= opb[OPW-1:BLOCK];
        end
      end
    end else begin : g_last
      logic cmsb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (adv && vld_in) begin
          cmsb_q <= opa[BLOCK-1] ^ opb[BLOCK-1] ^ res[BLOCK-1];
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign s         = g_stg[NSTG-1].sum_q;
  assign c         = g_stg[NSTG-1].cy_q;
  assign ovf       = g_stg[NSTG-1].g_last.cmsb_q ^ g_stg[NSTG-1].cy_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb/tb_pipelined_carry_select_adder.sv - directed and model-checked bench for pipelined_carry_select_adder
module tb_pipelined_carry_select_adder;

  localparam int NB = 1000;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c, ovf;
  logic [15:0] a, b, s;

  logic        sw_valid, sw_ci, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        ir88, v88, c88, o88;
  logic        ir82, v82, c82, o82;
  logic        ir324, v324, c324, o324;
  logic [7:0]  s88, s82;
  logic [31:0] s324;

  logic [31:0] hist_a [NB];
  logic [31:0] hist_b [NB];
  logic        hist_ci [NB];
  logic        hist_sub [NB];

  beat_t       in_q[$];
  logic [17:0] exp_q[$];
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c), .ovf(ovf)
  );

  pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(8)) u_8x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir88), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .c_in(sw_ci), .sub(sw_sub), .out_valid(v88), .out_ready(1'b1), .s(s88), .c(c88), .ovf(o88)
  );

  pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(2)) u_8x2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir82), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .c_in(sw_ci), .sub(sw_sub), .out_valid(v82), .out_ready(1'b1), .s(s82), .c(c82), .ovf(o82)
  );

  pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(4)) u_32x4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir324), .a(sw_a), .b(sw_b),
    .c_in(sw_ci), .sub(sw_sub), .out_valid(v324), .out_ready(1'b1), .s(s324), .c(c324), .ovf(o324)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {carry_out, overflow, sum} using plain wide arithmetic.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic [63:0] mask, xe, ye, full;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    xe   = {32'b0, x} & mask;
    ye   = (sb ? ~{32'b0, y} : {32'b0, y}) & mask;
    full = xe + ye + ((sb || ci) ? 64'd1 : 64'd0);
    ov   = (xe[w-1] == ye[w-1]) && (full[w-1] != xe[w-1]);
    return {full[w], ov, full[31:0] & mask[31:0]};
  endfunction

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                      input logic [17:0] e);
    beat_t bt;
    bt.a = x; bt.b = y; bt.ci = ci; bt.sb = sb;
    in_q.push_back(bt);
    exp_q.push_back(e);
  endtask

  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " result"}, {out_valid, c, ovf, s}, {1'b1, ec, eo, es});
  endtask

  task automatic run_stream(input string tag, input int stall_after, input int stall_len);
    int          n_exp, got, stall, cyc, last;
    logic [18:0] held;
    beat_t       bt;
    n_exp = exp_q.size();
    got = 0; stall = 0; cyc = 0; last = 0; held = '0;
    while (got < n_exp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        if (stall == stall_len) begin
          check({tag, " stall valid"}, out_valid, 1);
          held = {out_valid, c, ovf, s};
        end else begin
          check({tag, " stall hold"}, {out_valid, c, ovf, s}, held);
        end
        check({tag, " stall in_ready"}, in_ready, 0);
        stall--;
      end
      if (out_valid && out_ready) begin
        check($sformatf("%s result %0d", tag, got), {c, ovf, s}, exp_q.pop_front());
        if (stall_len == 0 && got > 0) check({tag, " gap"}, cyc - last, 1);
        last = cyc;
        got++;
        if (got == stall_after) stall = stall_len;
      end
      if (in_ready && in_q.size() > 0) begin
        bt = in_q.pop_front();
        a = bt.a; b = bt.b; c_in = bt.ci; sub = bt.sb; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, " count"}, got, n_exp);
    @(negedge clk);
    check({tag, " drained"}, out_valid, 0);
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic sweep_chk(input string tag, input int t, input int lat, input int w,
                           input logic v, input logic cc, input logic oo, input logic [31:0] ss);
    int          j;
    logic [33:0] r;
    j = t - lat;
    if (j >= 0 && j < NB) begin
      r = ref_add(w, hist_a[j], hist_b[j], hist_ci[j], hist_sub[j]);
      check($sformatf("%s beat %0d", tag, j), {v, cc, oo, ss}, {1'b1, r});
    end else begin
      check($sformatf("%s idle t%0d", tag, t), v, 0);
    end
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic        rc, rs;
    logic [33:0] r;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {out_valid, c, ovf, s}, 0);
    check("reset sweep valid", {v88, v82, v324}, 0);
    rst_n = 1'b1;

    single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    push(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    push(16'h1234, 16'h0FFF, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2234});
    run_stream("add b2b", 0, 0);

    push(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    push(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    run_stream("sub b2b", 0, 0);

    for (int i = 0; i < 10; i++) begin
      rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      r = ref_add(16, rx, ry, rc, rs);
      push(rx[15:0], ry[15:0], rc, rs, {r[33], r[32], r[15:0]});
    end
    run_stream("stall", 2, 3);

    // Fill the pipe with the output stalled, then pulse reset mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'h1111 * 16'(i + 1); b = 16'h0101; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset valid", out_valid, 1);
    #2 rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'hABCD;
    #1 check("reset drop", {out_valid, c, ovf, s}, 0);
    #9 rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle %0d", i), out_valid, 0);
    end
    single("post-reset", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    for (int t = 0; t < NB + 10; t++) begin
      @(negedge clk);
      sweep_chk("8x8", t, 1, 8, v88, c88, o88, {24'b0, s88});
      sweep_chk("8x2", t, 4, 8, v82, c82, o82, {24'b0, s82});
      sweep_chk("32x4", t, 8, 32, v324, c324, o324, s324);
      if (t < NB) begin
        hist_a[t] = $urandom;
        hist_b[t] = $urandom;
        hist_ci[t] = 1'($urandom_range(0, 1));
        hist_sub[t] = 1'($urandom_range(0, 1));
        sw_a = hist_a[t]; sw_b = hist_b[t]; sw_ci = hist_ci[t]; sw_sub = hist_sub[t];
        sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
